// File: rtl/pwm_duty_meter.sv
// rtl/pwm_duty_meter.sv - PWM high-time / period / duty-cycle meter
//
// Purpose: measures an asynchronous PWM input in clk cycles. Each completed
// rising-to-rising period reports high time, period and a truncated duty value
// computed by a 7-bit restoring divider. It also detects a stuck-high or
// stuck-low input.
//
// Optional build macro: PWM_DEGLITCH_EN adds a stability filter of DEGLITCH
// cycles after the synchronizer.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   measurement enable (0 = idle, counters cleared)
//   pwm_in      in   asynchronous PWM input
//   high_cnt    out  last measured high time (cycles)
//   period_cnt  out  last measured period (cycles)
//   duty        out  floor(high_cnt*DUTY_SCALE/period_cnt)
//   meas_valid  out  one-cycle pulse when results update
//   busy        out  divider running
//   overrun     out  one-cycle pulse: period dropped because divider busy
//   stuck_high  out  input high for TIMEOUT cycles
//   stuck_low   out  input low for TIMEOUT cycles
module pwm_duty_meter #(
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 50_000_000,
  parameter int DUTY_SCALE = 100,
  parameter int DEGLITCH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty,
  output logic             meas_valid,
  output logic             busy,
  output logic             overrun,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam int NW = CNT_W + 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic r_sync1, r_sync2, r_prev;
  logic w_level, w_rise, w_fall, w_edge;

  logic [CNT_W-1:0] r_hcnt, r_lcnt, r_h, r_tmo;
  logic [CNT_W-1:0] w_hcnt_inc, w_lcnt_inc, w_p;
  logic [CNT_W:0]   w_p_sum;

  logic             r_busy;
  logic [2:0]       r_it;
  logic [NW-1:0]    r_rem, r_dvs;
  logic [5:0]       r_q;
  logic [CNT_W-1:0] r_h_d, r_p_d;
  logic             w_ge;

  logic [CNT_W-1:0] r_high_cnt, r_period_cnt;
  logic [6:0]       r_duty;
  logic             r_meas_valid, r_overrun, r_stuck_high, r_stuck_low;

  logic w_tmo, w_period_done, w_div_load, w_overrun, w_tmo_fire;

  // Input synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_DEGLITCH_EN
  localparam int DG_W = (DEGLITCH < 2) ? 1 : $clog2(DEGLITCH);
  logic [DG_W-1:0] r_dg_cnt;
  logic            r_dg_lvl;

  // Accept a new level only after DEGLITCH consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dg_cnt <= '0;
      r_dg_lvl <= 1'b0;
    end else if (r_sync2 == r_dg_lvl) begin
      r_dg_cnt <= '0;
    end else if (r_dg_cnt == DG_W'(DEGLITCH - 1)) begin
      r_dg_lvl <= r_sync2;
      r_dg_cnt <= '0;
    end else begin
      r_dg_cnt <= r_dg_cnt + 1'b1;
    end
  end

  assign w_level = r_dg_lvl;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_level;
  end

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;
  assign w_edge = w_rise | w_fall;

  // Saturating increments and period sum
  assign w_hcnt_inc = (&r_hcnt) ? r_hcnt : r_hcnt + 1'b1;
  assign w_lcnt_inc = (&r_lcnt) ? r_lcnt : r_lcnt + 1'b1;
  assign w_p_sum    = {1'b0, r_h} + {1'b0, r_lcnt};
  assign w_p        = w_p_sum[CNT_W] ? {CNT_W{1'b1}} : w_p_sum[CNT_W-1:0];

  // Timeout is suppressed while a stuck flag is already set, so a stuck
  // input produces a single meas_valid. An edge in the same cycle wins.
  assign w_tmo = (r_state != IDLE) && !w_edge && !(r_stuck_high | r_stuck_low) &&
                 (r_tmo == CNT_W'(TIMEOUT - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:      w_state_nxt = WAIT_RISE;
        WAIT_RISE: if (w_rise) w_state_nxt = HIGH;
        HIGH:      if (w_fall) w_state_nxt = LOW;
                   else if (w_tmo) w_state_nxt = WAIT_RISE;
        LOW:       if (w_rise) w_state_nxt = HIGH;
                   else if (w_tmo) w_state_nxt = WAIT_RISE;
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM: event outputs
  always_comb begin
    w_period_done = en && (r_state == LOW) && w_rise;
    w_div_load    = w_period_done && !r_busy;
    w_overrun     = w_period_done && r_busy;
    w_tmo_fire    = en && w_tmo;
  end

  // Edge-free cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tmo <= '0;
    else if (!en || (r_state == IDLE) || w_edge)
      r_tmo <= '0;
    else if (r_tmo != CNT_W'(TIMEOUT - 1))
      r_tmo <= r_tmo + 1'b1;
  end

  // High / low counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_lcnt <= '0;
      r_h    <= '0;
    end else if (!en) begin
      r_hcnt <= '0;
      r_lcnt <= '0;
      r_h    <= '0;
    end else begin
      case (r_state)
        WAIT_RISE: if (w_rise) r_hcnt <= CNT_W'(1);
        HIGH: begin
          if (w_fall) begin
            r_h    <= r_hcnt;
            r_lcnt <= CNT_W'(1);
          end else begin
            r_hcnt <= w_hcnt_inc;
          end
        end
        LOW: begin
          if (w_rise) r_hcnt <= CNT_W'(1);
          else        r_lcnt <= w_lcnt_inc;
        end
        default: ;
      endcase
    end
  end

  // Divider stage: the remainder is compared against the divisor scaled by 2^i,
  // i = 6..0. h <= p guarantees the quotient fits in 7 bits.
  assign w_ge = (r_rem >= r_dvs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_it         <= '0;
      r_rem        <= '0;
      r_dvs        <= '0;
      r_q          <= '0;
      r_h_d        <= '0;
      r_p_d        <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_duty       <= '0;
      r_meas_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      r_overrun    <= 1'b0;
      if (!en) begin
        r_busy <= 1'b0;
      end else if (w_tmo_fire) begin
        r_busy       <= 1'b0;
        r_high_cnt   <= '0;
        r_period_cnt <= '0;
        r_duty       <= w_level ? 7'(DUTY_SCALE) : 7'd0;
        r_stuck_high <= w_level;
        r_stuck_low  <= ~w_level;
        r_meas_valid <= 1'b1;
      end else begin
        if (w_edge && (r_state != IDLE)) begin
          r_stuck_high <= 1'b0;
          r_stuck_low  <= 1'b0;
        end
        r_overrun <= w_overrun;
        if (w_div_load) begin
          r_busy <= 1'b1;
          r_it   <= '0;
          r_rem  <= NW'(r_h) * NW'(DUTY_SCALE);
          r_dvs  <= NW'(w_p) << 6;
          r_q    <= '0;
          r_h_d  <= r_h;
          r_p_d  <= w_p;
        end else if (r_busy) begin
          if (r_it == 3'd7) begin
            // Eighth busy cycle: results are already presented.
            r_busy <= 1'b0;
          end else begin
            r_rem <= w_ge ? (r_rem - r_dvs) : r_rem;
            r_dvs <= r_dvs >> 1;
            r_q   <= {r_q[4:0], w_ge};
            r_it  <= r_it + 1'b1;
            if (r_it == 3'd6) begin
              r_duty       <= {r_q, w_ge};
              r_high_cnt   <= r_h_d;
              r_period_cnt <= r_p_d;
              r_meas_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign high_cnt   = r_high_cnt;
  assign period_cnt = r_period_cnt;
  assign duty       = r_duty;
  assign meas_valid = r_meas_valid;
  assign busy       = r_busy;
  assign overrun    = r_overrun;
  assign stuck_high = r_stuck_high;
  assign stuck_low  = r_stuck_low;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb/tb_pwm_duty_meter.sv - randomized self-checking bench for pwm_duty_meter
module tb_pwm_duty_meter;

  localparam int CNT_W = 32;
  localparam int TMO   = 1000;
  localparam int DS    = 100;
  localparam int DG    = 4;
`ifdef PWM_DEGLITCH_EN
  localparam int MINW  = 5;
`else
  localparam int MINW  = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic [6:0]       duty;
  logic             meas_valid, busy, overrun, stuck_high, stuck_low;

  pwm_duty_meter #(
    .CNT_W(CNT_W), .TIMEOUT(TMO), .DUTY_SCALE(DS), .DEGLITCH(DG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .duty(duty),
    .meas_valid(meas_valid), .busy(busy), .overrun(overrun),
    .stuck_high(stuck_high), .stuck_low(stuck_low)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    longint h;
    longint p;
    longint d;
  } meas_t;

  meas_t  exp_q[$];
  longint cyc = 0;

  // Reference model: works on pin-edge timestamps. A period completing at a
  // rising edge is accepted when at least 9 cycles have passed since the last
  // accepted one (the divider holds busy for 8 cycles); otherwise it is an overrun.
  bit     m_en = 0, m_have_rise = 0, m_have_acc = 0;
  longint m_rise_t = 0, m_fall_t = 0, m_acc_t = 0, m_last_h = 0;
  int     exp_ovr = 0, obs_ovr = 0;

  task automatic model_reset();
    m_have_rise = 0;
    m_have_acc  = 0;
  endtask

  task automatic model_edge(input bit lvl);
    meas_t m;
    if (!m_en) return;
    if (!lvl) begin
      m_fall_t = cyc;
    end else begin
      if (m_have_rise) begin
        if (!m_have_acc || (cyc - m_acc_t) >= 9) begin
          m.h = m_fall_t - m_rise_t;
          m.p = cyc - m_rise_t;
          m.d = (m.h * DS) / m.p;
          exp_q.push_back(m);
          m_last_h   = m.h;
          m_have_acc = 1;
          m_acc_t    = cyc;
        end else begin
          exp_ovr++;
        end
      end
      m_have_rise = 1;
      m_rise_t    = cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit lvl, input int n);
    if (lvl != pwm_in) begin
      pwm_in = lvl;
      model_edge(lvl);
    end
    repeat (n) tick();
  endtask

  task automatic pwm(input int h, input int l, input int n);
    repeat (n) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic drain(input string tag);
    repeat (20) tick();
    check_val({tag, "_pending"}, exp_q.size(), 0);
    check_val({tag, "_overruns"}, obs_ovr, exp_ovr);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_high_cnt"}, high_cnt, 0);
    check_val({tag, "_period_cnt"}, period_cnt, 0);
    check_val({tag, "_duty"}, duty, 0);
    check_val({tag, "_meas_valid"}, meas_valid, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_overrun"}, overrun, 0);
    check_val({tag, "_stuck_high"}, stuck_high, 0);
    check_val({tag, "_stuck_low"}, stuck_low, 0);
  endtask

  // Result monitor
  always @(negedge clk) begin
    meas_t m;
    if (rst_n) begin
      if (overrun) obs_ovr++;
      if (meas_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_valid", 1, 0);
        end else begin
          m = exp_q.pop_front();
          check_val("meas_high_cnt", high_cnt, m.h);
          check_val("meas_period_cnt", period_cnt, m.p);
          check_val("meas_duty", duty, m.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    meas_t tm;
    int h, l;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    m_en = 1;
    model_reset();
    drive(1'b0, 10);

    // Steady 30/100
    pwm(30, 70, 6);
    drain("t1");

`ifndef PWM_DEGLITCH_EN
    // Minimum-width pulses with overruns, then 50/200
    pwm(1, 2, 12);
    pwm(50, 150, 3);
    drain("t2");
    check_val("t2_duty25", duty, 25);
`endif

    // Randomized high/low widths
    for (int i = 0; i < 30; i++) begin
      h = $urandom_range(60, MINW);
      l = $urandom_range(60, MINW);
      pwm(h, l, 1);
    end
    drain("rand");

    // Stuck high, then stuck low
    pwm(20, 30, 2);
    drive(1'b1, 0);
    tm.h = 0; tm.p = 0; tm.d = DS;
    exp_q.push_back(tm);
    drive(1'b1, 980);
    check_val("t3_not_yet_stuck", stuck_high, 0);
    drive(1'b1, 40);
    check_val("t3_stuck_high", stuck_high, 1);
    check_val("t3_duty_full", duty, DS);
    check_val("t3_high_cnt0", high_cnt, 0);
    check_val("t3_period_cnt0", period_cnt, 0);
    drive(1'b1, 1100);
    model_reset();
    drive(1'b0, 10);
    check_val("t3_stuck_high_clr", stuck_high, 0);
    tm.h = 0; tm.p = 0; tm.d = 0;
    exp_q.push_back(tm);
    drive(1'b0, 1030);
    check_val("t3_stuck_low", stuck_low, 1);
    check_val("t3_duty_zero", duty, 0);
    drive(1'b1, 10);
    check_val("t3_stuck_low_clr", stuck_low, 0);
    drive(1'b0, 25);
    pwm(25, 25, 2);
    drain("t3");

    // Asynchronous reset while the divider is busy
    drive(1'b1, 5);
    check_val("t4_busy_before_rst", busy, 1);
    pwm_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t4_async");
    exp_q.delete();
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    drive(1'b0, 10);
    pwm(30, 20, 3);
    drain("t4");

    // Disable mid-high, re-enable mid-high
    drive(1'b1, 20);
    en = 1'b0;
    m_en = 0;
    drive(1'b1, 10);
    drive(1'b0, 15);
    drive(1'b1, 15);
    check_val("t5_hold_high_cnt", high_cnt, m_last_h);
    check_val("t5_busy_idle", busy, 0);
    en = 1'b1;
    m_en = 1;
    model_reset();
    drive(1'b1, 15);
    drive(1'b0, 20);
    drive(1'b1, 30);
    drive(1'b0, 20);
    drive(1'b1, 10);
    drive(1'b0, 10);
    drain("t5");
    check_val("t5_first_high_cnt", high_cnt, 30);
    check_val("t5_first_period_cnt", period_cnt, 50);

    // Short low glitch inside a 40-cycle high
    drive(1'b1, 15);
`ifdef PWM_DEGLITCH_EN
    m_en = 0;
    drive(1'b0, 2);
    drive(1'b1, 23);
    m_en = 1;
`else
    drive(1'b0, 2);
    drive(1'b1, 23);
`endif
    drive(1'b0, 30);
    drive(1'b1, 10);
    drive(1'b0, 10);
    drain("t6");
`ifdef PWM_DEGLITCH_EN
    check_val("t6_high_cnt", high_cnt, 40);
`else
    check_val("t6_high_cnt", high_cnt, 23);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Receive-side counterpart to the LED PWM generator: measures an incoming PWM waveform's high time, period and duty cycle, all in clk cycles.
- Used to close the loop on LED dimming outputs, or to decode PWM commands from another board.
- Sits between a board pin and control logic; all outputs are in the clk domain.

Parameters:
CNT_W, 32, width of high/period counters.
TIMEOUT, 50_000_000, cycles without an edge before the input is declared stuck; must be < 2^CNT_W-1.
DUTY_SCALE, 100, full-scale duty value; must be <= 127.
DEGLITCH, 4, cycles the input must be stable to be accepted (only with PWM_DEGLITCH_EN).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  measurement enable
pwm_in  in  1  asynchronous PWM input
high_cnt  out  CNT_W  last measured high time, cycles
period_cnt  out  CNT_W  last measured period, cycles
duty  out  7  floor(high_cnt*DUTY_SCALE/period_cnt)
meas_valid  out  1  one-cycle pulse when high_cnt/period_cnt/duty update
busy  out  1  divider running
overrun  out  1  one-cycle pulse: completed period discarded because divider busy
stuck_high  out  1  input high for TIMEOUT cycles
stuck_low  out  1  input low for TIMEOUT cycles

Behaviour:
- Reset: one clock, async active-low rst_n. All outputs and internal registers are 0 while rst_n=0; state IDLE.
- Input path: 2-FF synchronizer (reset 0), then edge detect on the synced level. Pin edge to detected edge is 3 cycles.
- Counting: with steady input high for H cycles and period P, the block reports high_cnt=H and period_cnt=P exactly. Counters saturate; they never wrap.
- FSM:
  - IDLE: while en=0. en=1 -> WAIT_RISE.
  - WAIT_RISE: discards the partial period. Rising edge -> HIGH; hcnt=1.
  - HIGH: hcnt++. Falling edge -> LOW; latch h=hcnt; lcnt=1.
  - LOW: lcnt++. Rising edge -> period complete (p=h+lcnt). Returns to HIGH with hcnt=1 in the same cycle, so measurement is continuous.
- en=0 in any state: synchronous return to IDLE; counters cleared; outputs hold their last values; an in-flight divide is aborted with no meas_valid.
- Divider:
  - On period complete with busy=0: load numerator h*DUTY_SCALE (CNT_W+7 bits) and divisor p.
  - Restoring division, 7 quotient bits, one bit per cycle. busy=1 for 8 cycles (1 load + 7 iterations).
  - On the 8th cycle, register high_cnt=h, period_cnt=p and duty, and pulse meas_valid for 1 cycle.
  - meas_valid is therefore 8 cycles after the detected period-ending rising edge. Duty is truncated, never rounded.
- Overrun: period complete while busy=1 -> that result is discarded and overrun pulses for 1 cycle. Counting is unaffected.
- Timeout: in WAIT_RISE/HIGH/LOW, TIMEOUT consecutive cycles with no edge causes:
  - stuck_high or stuck_low set per the synced level;
  - high_cnt=period_cnt=0 and duty=DUTY_SCALE (high) or 0 (low);
  - one meas_valid pulse (bypassing the divider; any in-flight divide is aborted);
  - state -> WAIT_RISE.
- Stuck flags clear on the next detected edge. No repeated meas_valid while still stuck.
- Simultaneous events:
  - en=0 takes priority over everything.
  - Timeout and edge in the same cycle: the edge wins.

Optional Feature:
PWM_DEGLITCH_EN:
- Defined: a filter after the synchronizer updates the accepted level only after the synced input has differed from it for DEGLITCH consecutive cycles. Pulses shorter than DEGLITCH are ignored. Detection latency grows by DEGLITCH cycles; measured H and P are unchanged for clean input.
- Undefined: the synced level is used directly; no filter logic is present.

Test Plan:
1. en=1, PWM period 100, high 30 -> after the first full period, meas_valid every 100 cycles with high_cnt=30, period_cnt=100, duty=30, overrun never asserted.
2. PWM high 1, period 3 -> each meas_valid shows 1/3/33. overrun pulses for periods completing while busy (2 of every 3). A later step to high 50/period 200 -> duty=25.
3. TIMEOUT=1000, input held high after edges -> exactly 1000 cycles after the last detected edge: stuck_high=1, duty=100, counts 0, single meas_valid. The next falling edge clears stuck_high.
4. rst_n asserted during busy=1 -> all outputs 0 immediately (async). After release, no meas_valid until a rising edge plus one full period plus 8 cycles.
5. en dropped mid-HIGH -> no meas_valid, outputs hold. Re-enable mid-high -> the first result comes only after the next full rising-to-rising period.
6. 2-cycle low glitch inside a 40-cycle high, DEGLITCH=4:
   - PWM_DEGLITCH_EN defined -> glitch ignored, high_cnt=40.
   - Undefined -> a spurious measurement whose high_cnt is the cycles before the glitch.
